// File: rtl/traffic_light_controller.sv
// traffic_light_controller: phase sequencer for a main/side road intersection with a pedestrian
// crossing, driving the single shared interval timer and decoding the lamp outputs from state.
module traffic_light_controller #(
    parameter logic [4:0] MAIN_LEN   = 5'd20,
    parameter logic [4:0] SIDE_LEN   = 5'd15,
    parameter logic [4:0] YELLOW_LEN = 5'd5,
    parameter logic [4:0] ALLRED_LEN = 5'd2,
    parameter logic [4:0] WALK_LEN   = 5'd12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_sensor,
    input  logic       ped_req,
    input  logic       t_done,
    input  logic       t_flicker,
    output logic       t_start,
    output logic [4:0] t_length,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       walk_flash,
    output logic       ped_pending
);
    typedef enum logic [2:0] {BOOT, MAIN_G, MAIN_Y, RED1, SIDE_G, SIDE_Y, WALK, RED2} state_t;
    state_t state, next;
    logic   qd, ped_next;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            t_start     <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state       <= next;
            t_start     <= next != state;
            ped_pending <= ped_next;
        end
    end
    always_comb begin
        next = state;
        // a done seen alongside t_start belongs to the previous interval
        qd   = t_done & ~t_start;
        case (state)
            BOOT:    next = RED2;
            MAIN_G:  if (qd && (side_sensor || ped_pending)) next = MAIN_Y;
            MAIN_Y:  if (qd) next = RED1;
            RED1:    if (qd) next = ped_pending ? WALK : SIDE_G;
            SIDE_G:  if (qd) next = SIDE_Y;
            SIDE_Y:  if (qd) next = RED2;
            WALK:    if (qd) next = RED2;
            RED2:    if (qd) next = MAIN_G;
            default: next = BOOT;
        endcase
        ped_next   = (next == WALK && state != WALK) ? 1'b0 :
                     (ped_req && state != WALK)      ? 1'b1 : ped_pending;
        main_light = state == MAIN_G ? 3'b001 : state == MAIN_Y ? 3'b010 : 3'b100;
        side_light = state == SIDE_G ? 3'b001 : state == SIDE_Y ? 3'b010 : 3'b100;
        walk       = state == WALK;
        walk_flash = walk & t_flicker;
        t_length   = state == MAIN_G                   ? MAIN_LEN   :
                     state == SIDE_G                   ? SIDE_LEN   :
                     (state == MAIN_Y || state == SIDE_Y) ? YELLOW_LEN :
                     (state == RED1 || state == RED2)  ? ALLRED_LEN :
                     state == WALK                     ? WALK_LEN   : 5'd0;
    end
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed scenarios with a timer model and a queue of expected
// phase entries checked at every t_start pulse, plus per-cycle lamp invariant checks.
module tb_traffic_light_controller;
    logic       clk = 1'b0, reset = 1'b0;
    logic       side_sensor = 1'b0, ped_req = 1'b0, force_done = 1'b0;
    logic       t_done, t_flicker, t_start, walk, walk_flash, ped_pending, tm_done;
    logic [4:0] t_length, cnt;
    logic [2:0] main_light, side_light;
    int         n_cmp = 0, n_bad = 0, flash_seen = 0;

    typedef struct packed {logic [2:0] m; logic [2:0] s; logic w; logic [4:0] len;} exp_t;
    exp_t q[$];
    localparam exp_t MG = {3'b001, 3'b100, 1'b0, 5'd20};
    localparam exp_t MY = {3'b010, 3'b100, 1'b0, 5'd5};
    localparam exp_t R1 = {3'b100, 3'b100, 1'b0, 5'd2};
    localparam exp_t SG = {3'b100, 3'b001, 1'b0, 5'd15};
    localparam exp_t SY = {3'b100, 3'b010, 1'b0, 5'd5};
    localparam exp_t WK = {3'b100, 3'b100, 1'b1, 5'd12};
    localparam exp_t R2 = {3'b100, 3'b100, 1'b0, 5'd2};

    traffic_light_controller dut (
        .clk(clk), .reset(reset), .side_sensor(side_sensor), .ped_req(ped_req),
        .t_done(t_done), .t_flicker(t_flicker), .t_start(t_start), .t_length(t_length),
        .main_light(main_light), .side_light(side_light), .walk(walk),
        .walk_flash(walk_flash), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    // timer model: done rises t_length-1 edges after the t_start edge, clears on next t_start
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 5'd0;
            tm_done <= 1'b0;
        end else if (t_start) begin
            cnt     <= 5'(t_length - 5'd1);
            tm_done <= 1'b0;
        end else if (cnt != 5'd0) begin
            cnt     <= 5'(cnt - 5'd1);
            tm_done <= cnt == 5'd1;
        end
    end
    assign t_flicker = cnt != 5'd0 && cnt <= 5'd3;
    assign t_done    = tm_done | force_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("sb_timeout_left", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("inv_roads", 32'((main_light != 3'b100) && (side_light != 3'b100)), 0);
            chk("inv_walk", 32'(walk && (main_light != 3'b100 || side_light != 3'b100)), 0);
            chk("walk_flash", walk_flash, walk & t_flicker);
            if (walk_flash) flash_seen++;
            if (t_start) begin
                if (q.size() == 0) chk("sb_unexpected_tstart", t_start, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_main", main_light, e.m);
                    chk("sb_side", side_light, e.s);
                    chk("sb_walk", walk, e.w);
                    chk("sb_len", t_length, e.len);
                    if (e.w) chk("sb_ped_clr", ped_pending, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tstart", t_start, 0);
        chk("rst_tlen", t_length, 0);
        chk("rst_main", main_light, 3'b100);
        chk("rst_side", side_light, 3'b100);
        chk("rst_walk", walk, 0);
        chk("rst_flash", walk_flash, 0);
        chk("rst_ped", ped_pending, 0);
        // boot, then all-red clearance, then main green held with no request
        q.push_back(R2); q.push_back(MG);
        reset = 1'b1;
        #1 chk("boot_main", main_light, 3'b100);
        chk("boot_tstart", t_start, 0);
        wait_q(100);
        repeat (100) @(negedge clk);
        chk("hold_main", main_light, 3'b001);
        chk("hold_done", t_done, 1);
        // one-cycle side request while done is held
        q.push_back(MY); q.push_back(R1); q.push_back(SG);
        q.push_back(SY); q.push_back(R2); q.push_back(MG);
        side_sensor = 1'b1;
        @(negedge clk);
        side_sensor = 1'b0;
        chk("my_main", main_light, 3'b010);
        chk("my_tstart", t_start, 1);
        chk("my_len", t_length, 5);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        chk("stale_main", main_light, 3'b010);
        chk("stale_tstart", t_start, 0);
        wait_q(200);
        // pedestrian pulse while the main timer runs
        repeat (3) @(negedge clk);
        q.push_back(MY); q.push_back(R1); q.push_back(WK); q.push_back(R2); q.push_back(MG);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("ped_set", ped_pending, 1);
        chk("ped_main_still", main_light, 3'b001);
        wait_q(200);
        chk("flash_seen", 32'(flash_seen > 0), 1);
        // side and pedestrian together; ped_req held across WALK entry and into WALK
        repeat (2) @(negedge clk);
        q.push_back(MY); q.push_back(R1); q.push_back(WK); q.push_back(R2); q.push_back(MG);
        q.push_back(MY); q.push_back(R1); q.push_back(SG); q.push_back(SY); q.push_back(R2);
        q.push_back(MG);
        side_sensor = 1'b1;
        ped_req = 1'b1;
        for (int k = 0; k < 200 && !walk; k++) @(negedge clk);
        chk("walk_reached", walk, 1);
        chk("walk_entry_ped", ped_pending, 0);
        repeat (3) begin
            @(negedge clk);
            chk("walk_mid_ped", ped_pending, 0);
        end
        ped_req = 1'b0;
        wait_q(300);
        side_sensor = 1'b0;
        // reset in the middle of side green
        q.push_back(MY); q.push_back(R1); q.push_back(SG);
        side_sensor = 1'b1;
        wait_q(200);
        side_sensor = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_side", side_light, 3'b001);
        reset = 1'b0;
        #1;
        chk("arst_main", main_light, 3'b100);
        chk("arst_side", side_light, 3'b100);
        chk("arst_tstart", t_start, 0);
        chk("arst_tlen", t_length, 0);
        chk("arst_walk", walk, 0);
        chk("arst_ped", ped_pending, 0);
        @(negedge clk);
        q.push_back(R2); q.push_back(MG);
        reset = 1'b1;
        #1 chk("reboot_tstart", t_start, 0);
        wait_q(100);
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
